if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  MIPS instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
//  - Owns the PC and drives a request/grant/response instruction-memory port.
//  - Presents {PCp4_o, ins_o, valid_o} for IF/ID to latch.
//  - Honours a hazard stall and a branch/jump redirect; squashes stale fetches.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; low 2 bits must be 0
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  reset          in   1   asynchronous, active-high reset
//  stall_i        in   1   hazard unit: IF/ID not accepting this cycle
//  redirect_i     in   1   branch/jump taken; flush the fetch path
//  redirect_pc_i  in   32  target PC for redirect_i
//  imem_req_o     out  1   fetch request valid
//  imem_addr_o    out  32  fetch address (= pc_q)
//  imem_gnt_i     in   1   memory accepts request this cycle (when imem_req_o=1)
//  imem_rvalid_i  in   1   response valid; at most one outstanding
//  imem_rdata_i   in   32  instruction word for the oldest granted request
//  PCp4_o         out  32  fetched PC + 4
//  ins_o          out  32  fetched instruction; 32'h0 (sll $0 NOP) when valid_o=0
//  valid_o        out  1   PCp4_o/ins_o hold a real instruction
// BEHAVIOUR
//  - Reset (async, active-high): pc_q=RESET_PC, state=S_REQ, valid_o=0, ins_o=0, PCp4_o=0,
//    skid empty, drop=0. Outputs return to these values immediately on assertion,
//    including mid-fetch; any response arriving after reset deasserts is ignored
//    unless a request was granted after reset.
//  - Output slot drains when valid_o && !stall_i. The slot is free when !valid_o or draining.
//    If the slot drains and nothing loads it, next valid_o=0 and ins_o=0.
//  - States:
//    - S_REQ:  imem_req_o=1.
//      - On gnt: fetch_pc<=pc_q, pc_q<=pc_q+4, goto S_WAIT.
//    - S_WAIT: imem_req_o=0.
//      - On rvalid with drop=1: discard the data, drop<=0, goto S_REQ.
//      - On rvalid with slot free: slot<={fetch_pc+4, rdata, 1}, goto S_REQ.
//      - On rvalid with slot busy: skid<={fetch_pc+4, rdata}, goto S_HOLD.
//    - S_HOLD: imem_req_o=0.
//      - When !stall_i: slot<=skid (valid_o stays 1), goto S_REQ.
//  - Latency: gnt in cycle N, rvalid in N+1 -> valid_o in N+2. Peak rate is 1 instr per 2 cycles.
//  - Redirect (highest priority; overrides stall_i, rvalid and gnt in the same cycle):
//    - pc_q <= {redirect_pc_i[31:2], 2'b00}; valid_o<=0; ins_o<=0; skid cleared.
//    - In S_WAIT without same-cycle rvalid: drop<=1, stay in S_WAIT.
//    - In S_WAIT with same-cycle rvalid: data dropped, goto S_REQ.
//    - In S_REQ with same-cycle gnt: the old-PC request is in flight; drop<=1, goto S_WAIT.
//      pc_q takes the target, not old+4.
//    - Otherwise: goto S_REQ.
//  - PC arithmetic is 32-bit modulo: pc_q=32'hFFFF_FFFC -> next 32'h0000_0000.
//    PCp4_o wraps the same way.
//  - Unexpected rvalid in S_REQ/S_HOLD is ignored. imem_addr_o is stable while req && !gnt.
// CONFIGURATION
//  IF_ADEL_EN defined:
//    - Adds output adel_o (1 bit, reset 0).
//    - A redirect with redirect_pc_i[1:0]!=0 does not fetch. The next cycle:
//      valid_o=1, ins_o=0, PCp4_o=redirect_pc_i+4, adel_o=1.
//    - The stage then parks (no req) until the next redirect.
//    - adel_o clears on any redirect.
//  IF_ADEL_EN undefined:
//    - No adel_o port; the low 2 bits of redirect_pc_i are forced to 0 silently.
// TESTING
//  1. Reset, RESET_PC=0, gnt=1, rvalid one cycle later, stall=0 ->
//     imem_addr_o 0,4,8...; valid_o pulses with PCp4_o=4,8,12, ins_o = memory words.
//  2. Response arrives while stall_i=1 and slot full ->
//     skid holds; imem_req_o=0; on stall release, ins_o = second word; no word lost/duplicated.
//  3. Redirect to 32'h0000_0100 in S_WAIT; rvalid returns the PC=8 word next cycle ->
//     word discarded, valid_o=0; next request addr=32'h100.
//  4. redirect_i and gnt in the same S_REQ cycle ->
//     returning word dropped; next request addr = target; pc never = old+4.
//  5. Redirect to 32'hFFFF_FFFC ->
//     fetch yields PCp4_o=32'h0; the following request addr=32'h0.
//  6. Assert reset mid-S_WAIT ->
//     valid_o=0, ins_o=0 immediately; after release, first addr=RESET_PC.
//     With IF_ADEL_EN: redirect to 32'h102 -> adel_o=1, valid_o=1, ins_o=0, no req.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction-fetch stage.
// Owns the PC and drives a req/gnt/rvalid instruction-memory port with at most one
// fetch outstanding. It presents {PCp4_o, ins_o, valid_o} to the IF/ID register,
// with a one-entry skid buffer to absorb a response that lands while IF/ID stalls.
// A redirect flushes the fetch path; a stale in-flight response is dropped.
// Optional feature macro: IF_ADEL_EN (misaligned redirect target -> adel_o, park).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PCp4_o,
    output logic [31:0] ins_o,
    output logic        valid_o
`ifdef IF_ADEL_EN
   ,output logic        adel_o
`endif
);

    // S_PARK is only entered when misaligned-target detection is enabled
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_PARK} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic        r_drop;
    logic        r_valid;
    logic [31:0] r_ins;
    logic [31:0] r_pcp4;
    logic [31:0] r_skid_pcp4;
    logic [31:0] r_skid_ins;
    logic        r_adel;

    logic        w_drain;
    logic        w_slot_free;
    logic        w_inflight;
    logic        w_misalign;
    logic [31:0] w_fetch_pcp4;

    // Slot handshake, plus whether a response is still owed to us by memory
    always_comb begin
        w_drain      = r_valid && !stall_i;
        w_slot_free  = !r_valid || w_drain;
        w_fetch_pcp4 = r_fetch_pc + 32'd4;
        w_inflight   = ((r_state == S_REQ)  && imem_gnt_i) ||
                       ((r_state == S_WAIT) && !imem_rvalid_i) ||
                       ((r_state == S_PARK) && r_drop && !imem_rvalid_i);
`ifdef IF_ADEL_EN
        w_misalign   = (redirect_pc_i[1:0] != 2'b00);
`else
        w_misalign   = 1'b0;
`endif
    end

    // Fetch FSM, PC, output slot and skid buffer; redirect overrides everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_fetch_pc  <= 32'h0;
            r_drop      <= 1'b0;
            r_valid     <= 1'b0;
            r_ins       <= 32'h0;
            r_pcp4      <= 32'h0;
            r_skid_pcp4 <= 32'h0;
            r_skid_ins  <= 32'h0;
            r_adel      <= 1'b0;
        end else begin
            // a drained slot empties unless a load below overrides it
            if (w_drain) begin
                r_valid <= 1'b0;
                r_ins   <= 32'h0;
            end
            if (redirect_i) begin
                // low PC bits are masked so a misaligned target never reaches memory
                r_pc        <= redirect_pc_i & 32'hFFFF_FFFC;
                r_valid     <= 1'b0;
                r_ins       <= 32'h0;
                r_skid_pcp4 <= 32'h0;
                r_skid_ins  <= 32'h0;
                r_drop      <= w_inflight;
                r_adel      <= w_misalign;
                if (w_misalign) begin
                    // present an address-error bubble and stop fetching
                    r_valid <= 1'b1;
                    r_pcp4  <= redirect_pc_i + 32'd4;
                    r_state <= S_PARK;
                end else begin
                    r_state <= w_inflight ? S_WAIT : S_REQ;
                end
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (imem_gnt_i) begin
                            r_fetch_pc <= r_pc;
                            r_pc       <= r_pc + 32'd4;
                            r_state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid_i) begin
                            if (r_drop) begin
                                r_drop  <= 1'b0;
                                r_state <= S_REQ;
                            end else if (w_slot_free) begin
                                r_valid <= 1'b1;
                                r_ins   <= imem_rdata_i;
                                r_pcp4  <= w_fetch_pcp4;
                                r_state <= S_REQ;
                            end else begin
                                r_skid_pcp4 <= w_fetch_pcp4;
                                r_skid_ins  <= imem_rdata_i;
                                r_state     <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        // slot is valid here, so !stall_i means it drains now
                        if (!stall_i) begin
                            r_valid <= 1'b1;
                            r_ins   <= r_skid_ins;
                            r_pcp4  <= r_skid_pcp4;
                            r_state <= S_REQ;
                        end
                    end
                    default: begin
                        // parked: only soak up a response owed from before the park
                        if (imem_rvalid_i) r_drop <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign imem_req_o  = (r_state == S_REQ);
    assign imem_addr_o = r_pc;
    assign PCp4_o      = r_pcp4;
    assign ins_o       = r_ins;
    assign valid_o     = r_valid;
`ifdef IF_ADEL_EN
    assign adel_o      = r_adel;
`endif

endmodule
